bitstream_sng: RTL and testbench
================================

# bitstream_sng

- Stochastic number generator: converts a WIDTH-bit binary probability into a unipolar bitstream over one full LFSR period.
- Produces exactly `value` ones in 2^WIDTH−1 cycles.
- Sits at the input of the bitstream network and feeds bitstream consumers such as power/product stages.
- Pairs with the bitstream counter/decoder at the network output.

## Interface
- WIDTH, 8, value/seed/LFSR width; supported values 8, 10, 12, 16.
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a new stream; sampled only in IDLE.
- abort  in  1  terminate current stream; sampled only in RUN.
- value  in  WIDTH  probability numerator, captured on accepted start.
- seed  in  WIDTH  LFSR start state, captured on accepted start.
- busy  out  1  state is RUN.
- y  out  1  bitstream output, registered.
- y_valid  out  1  y carries a stream bit this cycle.
- last  out  1  high with the final (N-th) bit of a stream.
- value_b  in  WIDTH  second-stream probability (only with SNG_DECORRELATE_EN).
- y_b  out  1  second bitstream, qualified by y_valid (only with SNG_DECORRELATE_EN).

## Operation
- N = 2^WIDTH − 1 bits per stream.
- LFSR: Fibonacci, shift left, feedback XOR of tap bits into bit 0.
  - Taps (1-based): W=8 → 8,6,5,4; W=10 → 10,7; W=12 → 12,6,4,1; W=16 → 16,15,13,4.
  - Maximal length: visits every nonzero state once per N steps.
- Seed 0 is replaced by 1 at capture, so the LFSR never sticks.
- Comparison: bit = (lfsr <= value_r), unsigned WIDTH-bit.
  - value 0 gives all zeros; value 2^WIDTH−1 gives all ones.
  - Any value v gives exactly v ones per stream.
- FSM states: IDLE and RUN.
  - IDLE: on start=1, capture value_r, seed (zero-fixed) into lfsr, clear bit counter cnt, go to RUN.
  - RUN, each cycle:
    - register y and y_valid=1.
    - advance lfsr.
    - cnt++.
    - when cnt == N−1, also register last=1 and go to IDLE.
  - RUN with abort=1: go to IDLE. y, y_valid and last register 0. No bit is emitted. Abort has priority over the final bit.
- start is ignored in RUN. abort is ignored in IDLE; with start=1 and abort=1 in IDLE, start is accepted.
- cnt width is WIDTH; it never wraps within a stream.
- Reset, asynchronous:
  - state IDLE, lfsr=1, cnt=0, value_r=0.
  - y=0, y_b=0, y_valid=0, last=0, busy=0.
  - Reset mid-stream drops the stream silently with no last.

## Timing
- Start sampled at edge E0. Bits k=1..N are registered at edges E1..EN and visible in the cycle after each edge.
- Bit 1 uses lfsr = captured seed.
- busy is high after E0 through the cycle after E(N−1); it is low during the last-bit cycle.
- y_valid is high during the cycles after E1..EN. last is high only in the cycle after EN.
- Earliest next start is sampled at E(N+1). There is a one-cycle y_valid gap between back-to-back streams.
- Abort sampled at edge Ea: y_valid=0 and busy=0 in the following cycle. start is accepted from E(a+1).
- Latency from start to first valid bit: 1 cycle.

## Configuration
- SNG_DECORRELATE_EN defined: value_b and y_b ports exist.
  - value_b_r is captured with value.
  - y_b = (bitrev(lfsr) <= value_b_r), using the same LFSR state as y in the same cycle.
  - y_b gives a second, weakly correlated stream for two-input bitstream operators without a second LFSR.
  - y_b is 0 at reset and when y_valid=0.
- SNG_DECORRELATE_EN undefined: value_b and y_b ports and their logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, value=0, seed=1, start pulse → 255 valid bits, all 0; last only on bit 255; busy low on bit 255.
- value=255, seed=0x5A → 255 ones. value=128, seed=0x5A → exactly 128 ones; bit 1 = 1 (0x5A ≤ 128).
- seed=0, value=100 → stream identical to seed=1 with value=100, and has 100 ones. A second start pulse at bit 50 is ignored; the stream is unchanged.
- abort after bit 10 → next cycle y_valid=0, busy=0, last never asserted. start in the next cycle → first bit one cycle later, seed reloaded.
- Back-to-back streams: start held high → one-cycle y_valid gap between streams. n_rst low at bit 100 → all outputs 0 immediately; after release, state IDLE, no last.
- SNG_DECORRELATE_EN, value=128, value_b=64 → y has 128 ones and y_b has 64 ones in the same 255 cycles. With value=value_b, y and y_b are not identical.

Source files
------------

// File: rtl/bitstream_sng.sv
// Stochastic number generator: turns a WIDTH-bit probability into a unipolar bitstream
// over one full LFSR period. Optional second stream via macro SNG_DECORRELATE_EN.
module bitstream_sng #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] seed,
`ifdef SNG_DECORRELATE_EN
  input  logic [WIDTH-1:0] value_b,
  output logic             y_b,
`endif
  output logic             busy,
  output logic             y,
  output logic             y_valid,
  output logic             last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Tap masks for maximal-length Fibonacci LFSRs (bit i set = 1-based tap i+1).
  function automatic logic [WIDTH-1:0] tap_mask();
    logic [31:0] m;
    case (WIDTH)
      10:      m = 32'h0000_0240;
      12:      m = 32'h0000_0829;
      16:      m = 32'h0000_D008;
      default: m = 32'h0000_00B8;
    endcase
    return m[WIDTH-1:0];
  endfunction

  function automatic logic parity(input logic [WIDTH-1:0] x);
    return ^x;
  endfunction

`ifdef SNG_DECORRELATE_EN
  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction
`endif

  localparam logic [WIDTH-1:0] TAPS    = tap_mask();
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_END = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] value_r, value_s;
  logic             y_r, y_s;
  logic             y_valid_r, y_valid_s;
  logic             last_r, last_s;
`ifdef SNG_DECORRELATE_EN
  logic [WIDTH-1:0] value_b_r, value_b_s;
  logic             y_b_r, y_b_s;
`endif

  // Next-state and next-output logic; abort wins over the final bit.
  always_comb begin
    state_s   = state_r;
    lfsr_s    = lfsr_r;
    cnt_s     = cnt_r;
    value_s   = value_r;
    y_s       = 1'b0;
    y_valid_s = 1'b0;
    last_s    = 1'b0;
`ifdef SNG_DECORRELATE_EN
    value_b_s = value_b_r;
    y_b_s     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          value_s = value;
          lfsr_s  = (seed == {WIDTH{1'b0}}) ? ONE : seed;
          cnt_s   = {WIDTH{1'b0}};
`ifdef SNG_DECORRELATE_EN
          value_b_s = value_b;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          y_s       = (lfsr_r <= value_r);
          y_valid_s = 1'b1;
`ifdef SNG_DECORRELATE_EN
          y_b_s     = (bitrev(lfsr_r) <= value_b_r);
`endif
          lfsr_s    = {lfsr_r[WIDTH-2:0], parity(lfsr_r & TAPS)};
          cnt_s     = cnt_r + ONE;
          if (cnt_r == CNT_END) begin
            last_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = RUN;
          end
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      lfsr_r    <= ONE;
      cnt_r     <= {WIDTH{1'b0}};
      value_r   <= {WIDTH{1'b0}};
      y_r       <= 1'b0;
      y_valid_r <= 1'b0;
      last_r    <= 1'b0;
`ifdef SNG_DECORRELATE_EN
      value_b_r <= {WIDTH{1'b0}};
      y_b_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      lfsr_r    <= lfsr_s;
      cnt_r     <= cnt_s;
      value_r   <= value_s;
      y_r       <= y_s;
      y_valid_r <= y_valid_s;
      last_r    <= last_s;
`ifdef SNG_DECORRELATE_EN
      value_b_r <= value_b_s;
      y_b_r     <= y_b_s;
`endif
    end
  end

  assign busy    = (state_r == RUN);
  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign last    = last_r;
`ifdef SNG_DECORRELATE_EN
  assign y_b     = y_b_r;
`endif

endmodule

// File: tb/tb_bitstream_sng.sv
// Self-checking bench for bitstream_sng (WIDTH=8): table-driven streams, random
// streams, abort, mid-stream start, back-to-back, and reset corner cases.
module tb_bitstream_sng;
  localparam int N = 255;

  logic       clk = 1'b0;
  logic       n_rst, start, abort;
  logic [7:0] value, seed;
  logic       busy, y, y_valid, last;
`ifdef SNG_DECORRELATE_EN
  logic [7:0] value_b;
  logic       y_b;
`endif

  int errors = 0;
  int checks = 0;

  bitstream_sng #(.WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .value(value), .seed(seed),
`ifdef SNG_DECORRELATE_EN
    .value_b(value_b), .y_b(y_b),
`endif
    .busy(busy), .y(y), .y_valid(y_valid), .last(last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Wait (bounded) for the end of a stream.
  task automatic drain(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #1;
      if (last === 1'b1) seen = 1'b1;
    end
    check({tag, "_drain_last"}, seen, 1);
    @(posedge clk); #1;
  endtask

  // Runs one stream and compares every bit against the reference model.
  task automatic run_stream(input string tag, input logic [7:0] v, input logic [7:0] sd,
                            input logic [7:0] vb, input int abort_after,
                            input bit hold_start, input bit restart_mid,
                            input int exp_ones, input int exp_first);
    logic [7:0] s, s0;
    int ones, ones_b, bad, bad_b, lasts, busy_bad, diff, first;
    ones = 0; ones_b = 0; bad = 0; bad_b = 0; lasts = 0; busy_bad = 0; diff = 0; first = -1;
    s  = (sd == 8'd0) ? 8'd1 : sd;
    s0 = s;
    value = v; seed = sd; start = 1'b1;
`ifdef SNG_DECORRELATE_EN
    value_b = vb;
`endif
    @(posedge clk); #1;
    if (!hold_start) begin
      start = 1'b0;
      value = ~v; seed = ~sd;
`ifdef SNG_DECORRELATE_EN
      value_b = ~vb;
`endif
    end
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_no_valid_latency"}, y_valid, 0);
    for (int k = 1; k <= N; k++) begin
      if (restart_mid && k == 50) begin start = 1'b1; seed = 8'h33; value = 8'hF0; end
      if (restart_mid && k == 51) start = 1'b0;
      @(posedge clk); #1;
      if (k == 1) first = y;
      if (y_valid !== 1'b1 || y !== (s <= v)) bad++;
      if (last !== ((k == N) ? 1'b1 : 1'b0)) lasts++;
      if (busy !== ((k != N) ? 1'b1 : 1'b0)) busy_bad++;
      if (y === 1'b1) ones++;
`ifdef SNG_DECORRELATE_EN
      if (y_b !== (rev8(s) <= vb)) bad_b++;
      if (y_b === 1'b1) ones_b++;
      if (y_b !== y) diff++;
`endif
      s = lfsr_step(s);
      if (k == abort_after) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check({tag, "_bits_before_abort"}, bad, 0);
        check({tag, "_abort_y_valid"}, y_valid, 0);
        check({tag, "_abort_busy"}, busy, 0);
        check({tag, "_abort_last"}, last, 0);
        return;
      end
    end
    check({tag, "_bits"}, bad, 0);
    check({tag, "_last_pos"}, lasts, 0);
    check({tag, "_busy_profile"}, busy_bad, 0);
    check({tag, "_ones"}, ones, exp_ones);
    check({tag, "_first_bit"}, first, exp_first);
`ifdef SNG_DECORRELATE_EN
    check({tag, "_yb_bits"}, bad_b, 0);
    check({tag, "_yb_ones"}, ones_b, vb);
    if (v == vb) check({tag, "_yb_differs"}, (diff != 0), 1);
`endif
    @(posedge clk); #1;
    check({tag, "_gap_valid"}, y_valid, 0);
    check({tag, "_gap_last"}, last, 0);
    if (hold_start) begin
      check({tag, "_b2b_busy"}, busy, 1);
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, "_b2b_valid"}, y_valid, 1);
      check({tag, "_b2b_first"}, y, (s0 <= v));
      drain({tag, "_b2b"});
    end
  endtask

  typedef struct {
    logic [7:0] v;
    logic [7:0] sd;
    logic [7:0] vb;
    int         ones;
    int         first;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'd0,   8'd1,   8'd0,   0,   0};
    vecs[1] = '{8'd255, 8'h5A,  8'd255, 255, 1};
    vecs[2] = '{8'd128, 8'h5A,  8'd64,  128, 1};
    vecs[3] = '{8'd100, 8'd0,   8'd100, 100, 1};
    vecs[4] = '{8'd100, 8'd1,   8'd100, 100, 1};
    for (int i = 5; i < 10; i++) begin
      vecs[i].v     = 8'($urandom_range(0, 255));
      vecs[i].sd    = 8'($urandom_range(0, 255));
      vecs[i].vb    = 8'($urandom_range(0, 255));
      vecs[i].ones  = vecs[i].v;
      vecs[i].first = (((vecs[i].sd == 8'd0) ? 8'd1 : vecs[i].sd) <= vecs[i].v) ? 1 : 0;
    end

    n_rst = 1'b0; start = 1'b0; abort = 1'b0; value = 8'd0; seed = 8'd0;
`ifdef SNG_DECORRELATE_EN
    value_b = 8'd0;
`endif
    @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_y_valid", y_valid, 0);
    check("reset_last", last, 0);
    check("reset_y", y, 0);
    @(negedge clk); n_rst = 1'b1;

    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1 abort = 1'b0;
    check("idle_abort_ignored", busy, 0);

    for (int i = 0; i < 10; i++)
      run_stream($sformatf("vec%0d", i), vecs[i].v, vecs[i].sd, vecs[i].vb, -1, 1'b0, 1'b0,
                 vecs[i].ones, vecs[i].first);

    run_stream("midstart", 8'd100, 8'd0, 8'd100, -1, 1'b0, 1'b1, 100, 1);
    run_stream("abort", 8'd128, 8'h5A, 8'd64, 10, 1'b0, 1'b0, 0, 0);
    run_stream("after_abort", 8'd128, 8'h5A, 8'd64, -1, 1'b0, 1'b0, 128, 1);
    run_stream("b2b", 8'd77, 8'h21, 8'd200, -1, 1'b1, 1'b0, 77, 1);

    start = 1'b1; abort = 1'b1; value = 8'd10; seed = 8'd9;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", busy, 1);
    drain("start_abort");

    start = 1'b1; value = 8'd77; seed = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("rst_mid_y", y, 0);
    check("rst_mid_valid", y_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_last", last, 0);
`ifdef SNG_DECORRELATE_EN
    check("rst_mid_yb", y_b, 0);
`endif
    @(negedge clk); n_rst = 1'b1;
    begin
      int stray;
      stray = 0;
      repeat (300) begin
        @(posedge clk); #1;
        if (last !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0) stray++;
      end
      check("rst_release_idle", stray, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
